// File: rtl/core_mem_pipe_pkg.sv
// rtl/core_mem_pipe_pkg.sv - shared types for the MEM/writeback pipe: writeback select and stage entry.
package core_mem_pipe_pkg;

    localparam int MEM_DATA_W = 64;
    localparam int MEM_REG_W  = 5;

    typedef enum logic [1:0] {
        WB_ALU    = 2'd0,
        WB_LOAD   = 2'd1,
        WB_C0     = 2'd2,
        WB_LINKPC = 2'd3
    } wb_sel_t;

    typedef struct packed {
        logic                  valid;
        logic                  write_enable;
        logic                  ready;
        logic                  mmio;
        wb_sel_t               wb_sel;
        logic [MEM_REG_W-1:0]  W_regnum;
        logic [MEM_DATA_W-1:0] data;
    } mem_pipe_entry_t;

    // Load data is unknown until the merge, so a LOAD entry enters with zero data.
    function automatic logic [MEM_DATA_W-1:0] ex_result(
        input wb_sel_t               sel,
        input logic [MEM_DATA_W-1:0] alu_out,
        input logic [MEM_DATA_W-1:0] c0_data,
        input logic [MEM_DATA_W-1:0] pc4
    );
        case (sel)
            WB_C0:     return c0_data;
            WB_LINKPC: return pc4;
            WB_LOAD:   return '0;
            default:   return alu_out;
        endcase
    endfunction

endpackage

// File: rtl/core_mem_pipe_if.sv
// rtl/core_mem_pipe_if.sv - EX, cache/MMIO, writeback and forwarding bundle; trace signals under CORE_MEM_PIPE_TRACE_EN.
interface core_mem_pipe_if #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5,
    parameter int DEPTH  = 2
);
    logic                    ex_valid;
    logic [REG_W-1:0]        ex_W_regnum;
    logic                    ex_write_enable;
    logic [1:0]              ex_wb_sel;
    logic [DATA_W-1:0]       ex_alu_out;
    logic [DATA_W-1:0]       ex_pc4;
    logic [DATA_W-1:0]       ex_c0_data;
    logic                    ex_mmio;
    logic                    flush;
    logic [DATA_W-1:0]       dc_rdata;
    logic                    dc_miss;
    logic                    mem_ready;
    logic                    d_valid;
    logic [DATA_W-1:0]       d_rdata;
    logic                    miss_stall;
    logic                    wb_write_enable;
    logic [REG_W-1:0]        wb_W_regnum;
    logic [DATA_W-1:0]       wb_W_data;
    logic [DEPTH-1:0]        fwd_valid;
    logic [DEPTH*REG_W-1:0]  fwd_regnum;
    logic [DEPTH*DATA_W-1:0] fwd_data;
    logic [DEPTH-1:0]        fwd_ready;
`ifdef CORE_MEM_PIPE_TRACE_EN
    logic [DATA_W-1:0]       ex_pc;
    logic [31:0]             ex_inst;
    logic [DATA_W-1:0]       wb_pc;
    logic [31:0]             wb_inst;
`endif

    modport master (
        output ex_valid, ex_W_regnum, ex_write_enable, ex_wb_sel, ex_alu_out, ex_pc4,
               ex_c0_data, ex_mmio, flush, dc_rdata, dc_miss, mem_ready, d_valid, d_rdata,
        input  miss_stall, wb_write_enable, wb_W_regnum, wb_W_data,
               fwd_valid, fwd_regnum, fwd_data, fwd_ready
`ifdef CORE_MEM_PIPE_TRACE_EN
        , output ex_pc, ex_inst, input wb_pc, wb_inst
`endif
    );

    modport slave (
        input  ex_valid, ex_W_regnum, ex_write_enable, ex_wb_sel, ex_alu_out, ex_pc4,
               ex_c0_data, ex_mmio, flush, dc_rdata, dc_miss, mem_ready, d_valid, d_rdata,
        output miss_stall, wb_write_enable, wb_W_regnum, wb_W_data,
               fwd_valid, fwd_regnum, fwd_data, fwd_ready
`ifdef CORE_MEM_PIPE_TRACE_EN
        , input ex_pc, ex_inst, output wb_pc, wb_inst
`endif
    );
endinterface

// File: rtl/core_mem_pipe_stage.sv
// rtl/core_mem_pipe_stage.sv - one pipe entry register with clear, load and hold.
module mem_pipe_stage
    import core_mem_pipe_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_clear,
    input  logic            i_load,
    input  mem_pipe_entry_t i_entry,
    output mem_pipe_entry_t o_entry
);
    mem_pipe_entry_t r_entry;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_entry <= '0;
        end else if (i_clear) begin
            r_entry <= '0;
        end else if (i_load) begin
            r_entry <= i_entry;
        end
    end

    assign o_entry = r_entry;
endmodule

// File: rtl/core_mem_pipe.sv
// rtl/core_mem_pipe.sv - DEPTH-stage MEM/writeback pipe with load merge, miss freeze and per-stage forwarding.
// Optional trace of pc/inst through every stage when CORE_MEM_PIPE_TRACE_EN is defined.
module core_mem_pipe
    import core_mem_pipe_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int REG_W  = MEM_REG_W,
    parameter int DEPTH  = 2
) (
    input  logic           clock,
    input  logic           reset_n,
    core_mem_pipe_if.slave bus
);
    localparam int LAST = DEPTH - 1;

    mem_pipe_entry_t w_stage [DEPTH];
    mem_pipe_entry_t w_next  [DEPTH];
    mem_pipe_entry_t w_ex_entry;
    mem_pipe_entry_t w_merged;
    logic            w_stall;
    logic            w_s0_load;

    always_comb begin
        w_ex_entry              = '0;
        w_ex_entry.valid        = bus.ex_valid & ~bus.flush;
        w_ex_entry.write_enable = bus.ex_write_enable;
        w_ex_entry.mmio         = bus.ex_mmio;
        w_ex_entry.wb_sel       = wb_sel_t'(bus.ex_wb_sel);
        w_ex_entry.W_regnum     = bus.ex_W_regnum;
        w_ex_entry.ready        = (wb_sel_t'(bus.ex_wb_sel) != WB_LOAD);
        w_ex_entry.data         = ex_result(wb_sel_t'(bus.ex_wb_sel), bus.ex_alu_out,
                                            bus.ex_c0_data, bus.ex_pc4);
    end

    assign w_s0_load = (w_stage[0].wb_sel == WB_LOAD);

    // The merge only matters on an unfrozen cycle, when the selected source is known good.
    always_comb begin
        w_merged = w_stage[0];
        if (w_s0_load) begin
            w_merged.data  = w_stage[0].mmio ? bus.d_rdata : bus.dc_rdata;
            w_merged.ready = 1'b1;
        end
    end

    assign w_stall = w_stage[0].valid & w_s0_load &
                     ((~w_stage[0].mmio & bus.dc_miss & ~bus.mem_ready) |
                      (w_stage[0].mmio & ~bus.d_valid));

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign w_next[g] = w_ex_entry;
        end else if (g == 1) begin : g_merge
            assign w_next[g] = w_merged;
        end else begin : g_shift
            assign w_next[g] = w_stage[g-1];
        end

        mem_pipe_stage u_stage (
            .i_clk   (clock),
            .i_rst_n (reset_n),
            .i_clear (1'b0),
            .i_load  (~w_stall),
            .i_entry (w_next[g]),
            .o_entry (w_stage[g])
        );

        assign bus.fwd_valid[g] = w_stage[g].valid & w_stage[g].write_enable &
                                  (w_stage[g].W_regnum != '0);
        assign bus.fwd_ready[g] = w_stage[g].ready;
        assign bus.fwd_regnum[g*REG_W +: REG_W]   = w_stage[g].W_regnum;
        assign bus.fwd_data[g*DATA_W +: DATA_W]   = w_stage[g].data;
    end

    // A frozen tail entry is suppressed so it writes exactly once, on its first unfrozen cycle.
    assign bus.wb_write_enable = w_stage[LAST].valid & w_stage[LAST].write_enable &
                                 (w_stage[LAST].W_regnum != '0) & ~w_stall;
    assign bus.wb_W_regnum     = w_stage[LAST].W_regnum;
    assign bus.wb_W_data       = w_stage[LAST].data;
    assign bus.miss_stall      = w_stall;

`ifdef CORE_MEM_PIPE_TRACE_EN
    logic [DATA_W-1:0] r_pc   [DEPTH];
    logic [31:0]       r_inst [DEPTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]   <= '0;
                r_inst[i] <= '0;
            end
        end else if (!w_stall) begin
            r_pc[0]   <= bus.ex_pc;
            r_inst[0] <= bus.ex_inst;
            for (int i = 1; i < DEPTH; i++) begin
                r_pc[i]   <= r_pc[i-1];
                r_inst[i] <= r_inst[i-1];
            end
        end
    end

    assign bus.wb_pc   = r_pc[LAST];
    assign bus.wb_inst = r_inst[LAST];
`endif
endmodule

// File: tb/tb_core_mem_pipe.sv
// tb/tb_core_mem_pipe.sv - directed bench driving DEPTH=2 and DEPTH=4 pipes from one shared EX stream.
module tb_core_mem_pipe;
    import core_mem_pipe_pkg::*;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    logic        ex_valid, ex_write_enable, ex_mmio, flush, dc_miss, mem_ready, d_valid;
    logic [4:0]  ex_W_regnum;
    logic [1:0]  ex_wb_sel;
    logic [63:0] ex_alu_out, ex_pc4, ex_c0_data, dc_rdata, d_rdata;
    logic [19:0] exp_rn4;
    logic [9:0]  exp_rn2;
    int n_vec = 0;
    int n_err = 0;

    core_mem_pipe_if #(.DATA_W(64), .REG_W(5), .DEPTH(2)) if2 ();
    core_mem_pipe_if #(.DATA_W(64), .REG_W(5), .DEPTH(4)) if4 ();

    assign if2.ex_valid = ex_valid;               assign if4.ex_valid = ex_valid;
    assign if2.ex_W_regnum = ex_W_regnum;         assign if4.ex_W_regnum = ex_W_regnum;
    assign if2.ex_write_enable = ex_write_enable; assign if4.ex_write_enable = ex_write_enable;
    assign if2.ex_wb_sel = ex_wb_sel;             assign if4.ex_wb_sel = ex_wb_sel;
    assign if2.ex_alu_out = ex_alu_out;           assign if4.ex_alu_out = ex_alu_out;
    assign if2.ex_pc4 = ex_pc4;                   assign if4.ex_pc4 = ex_pc4;
    assign if2.ex_c0_data = ex_c0_data;           assign if4.ex_c0_data = ex_c0_data;
    assign if2.ex_mmio = ex_mmio;                 assign if4.ex_mmio = ex_mmio;
    assign if2.flush = flush;                     assign if4.flush = flush;
    assign if2.dc_rdata = dc_rdata;               assign if4.dc_rdata = dc_rdata;
    assign if2.dc_miss = dc_miss;                 assign if4.dc_miss = dc_miss;
    assign if2.mem_ready = mem_ready;             assign if4.mem_ready = mem_ready;
    assign if2.d_valid = d_valid;                 assign if4.d_valid = d_valid;
    assign if2.d_rdata = d_rdata;                 assign if4.d_rdata = d_rdata;
`ifdef CORE_MEM_PIPE_TRACE_EN
    assign if2.ex_pc = '0;   assign if4.ex_pc = '0;
    assign if2.ex_inst = '0; assign if4.ex_inst = '0;
`endif

    core_mem_pipe #(.DATA_W(64), .REG_W(5), .DEPTH(2)) u_dut2 (.clock(clock), .reset_n(reset_n), .bus(if2));
    core_mem_pipe #(.DATA_W(64), .REG_W(5), .DEPTH(4)) u_dut4 (.clock(clock), .reset_n(reset_n), .bus(if4));

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    task automatic set_idle();
        ex_valid = 0; ex_write_enable = 0; ex_mmio = 0; flush = 0;
        dc_miss = 0; mem_ready = 0; d_valid = 0;
        ex_W_regnum = 0; ex_wb_sel = 0;
        ex_alu_out = 0; ex_pc4 = 0; ex_c0_data = 0; dc_rdata = 0; d_rdata = 0;
    endtask

    task automatic drive(input logic [4:0] rn, input wb_sel_t sel, input logic [63:0] val, input logic mmio);
        ex_valid = 1; ex_write_enable = 1; ex_W_regnum = rn; ex_wb_sel = sel;
        ex_alu_out = val; ex_c0_data = val; ex_pc4 = val; ex_mmio = mmio; flush = 0;
    endtask

    task automatic drain();
        set_idle();
        repeat (5) cyc();
    endtask

    task automatic test_reset();
        set_idle();
        #1 reset_n = 0;
        #1;
        n_vec++; if (if2.miss_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %b exp 0", if2.miss_stall); end
        n_vec++; if (if2.wb_write_enable !== 1'b0) begin n_err++; $display("FAIL rst_wb_we got %b exp 0", if2.wb_write_enable); end
        n_vec++; if (if2.wb_W_regnum !== 5'd0) begin n_err++; $display("FAIL rst_wb_rn got %h exp 0", if2.wb_W_regnum); end
        n_vec++; if (if2.wb_W_data !== 64'd0) begin n_err++; $display("FAIL rst_wb_data got %h exp 0", if2.wb_W_data); end
        n_vec++; if (if2.fwd_valid !== 2'b00) begin n_err++; $display("FAIL rst_fwd_valid got %b exp 00", if2.fwd_valid); end
        n_vec++; if (if2.fwd_ready !== 2'b00) begin n_err++; $display("FAIL rst_fwd_ready got %b exp 00", if2.fwd_ready); end
        n_vec++; if (if4.fwd_regnum !== 20'd0) begin n_err++; $display("FAIL rst_fwd_rn4 got %h exp 0", if4.fwd_regnum); end
        @(negedge clock) reset_n = 1;
        drain();
    endtask

    task automatic test_alu();
        drive(5'd3, WB_ALU, 64'h1234, 1'b0);
        cyc(); set_idle(); smp();
        n_vec++; if (if2.fwd_valid !== 2'b01) begin n_err++; $display("FAIL alu_fwd_valid got %b exp 01", if2.fwd_valid); end
        n_vec++; if (if2.fwd_ready[0] !== 1'b1) begin n_err++; $display("FAIL alu_fwd_ready0 got %b exp 1", if2.fwd_ready[0]); end
        n_vec++; if (if2.fwd_regnum[4:0] !== 5'd3) begin n_err++; $display("FAIL alu_fwd_rn0 got %0d exp 3", if2.fwd_regnum[4:0]); end
        n_vec++; if (if2.wb_write_enable !== 1'b0) begin n_err++; $display("FAIL alu_wb_early got %b exp 0", if2.wb_write_enable); end
        cyc(); smp();
        n_vec++; if (if2.wb_write_enable !== 1'b1) begin n_err++; $display("FAIL alu_wb_we got %b exp 1", if2.wb_write_enable); end
        n_vec++; if (if2.wb_W_regnum !== 5'd3) begin n_err++; $display("FAIL alu_wb_rn got %0d exp 3", if2.wb_W_regnum); end
        n_vec++; if (if2.wb_W_data !== 64'h1234) begin n_err++; $display("FAIL alu_wb_data got %h exp 1234", if2.wb_W_data); end
        n_vec++; if (if4.wb_write_enable !== 1'b0) begin n_err++; $display("FAIL alu_wb4_early got %b exp 0", if4.wb_write_enable); end
        cyc(); smp();
        n_vec++; if (if2.wb_write_enable !== 1'b0) begin n_err++; $display("FAIL alu_wb_once got %b exp 0", if2.wb_write_enable); end
        cyc(); smp();
        n_vec++; if (if4.wb_write_enable !== 1'b1 || if4.wb_W_data !== 64'h1234) begin
            n_err++; $display("FAIL alu_wb4 got we=%b data=%h exp we=1 data=1234", if4.wb_write_enable, if4.wb_W_data); end
        drain();
    endtask

    task automatic test_sel();
        drive(5'd10, WB_C0, 64'hAAAA, 1'b0); ex_c0_data = 64'hC0C0; ex_pc4 = 64'h4444;
        cyc(); drive(5'd11, WB_LINKPC, 64'hBBBB, 1'b0); ex_c0_data = 64'h1111; ex_pc4 = 64'h400;
        cyc(); set_idle(); smp();
        n_vec++; if (if2.wb_W_data !== 64'hC0C0 || if2.wb_W_regnum !== 5'd10) begin
            n_err++; $display("FAIL sel_c0 got rn=%0d data=%h exp rn=10 data=c0c0", if2.wb_W_regnum, if2.wb_W_data); end
        cyc(); smp();
        n_vec++; if (if2.wb_W_data !== 64'h400 || if2.wb_W_regnum !== 5'd11) begin
            n_err++; $display("FAIL sel_linkpc got rn=%0d data=%h exp rn=11 data=400", if2.wb_W_regnum, if2.wb_W_data); end
        drain();
    endtask

    task automatic test_cache_miss();
        drive(5'd5, WB_LOAD, 64'h0, 1'b0);
        cyc(); set_idle(); dc_miss = 1; mem_ready = 0; smp();
        n_vec++; if (if2.fwd_valid[0] !== 1'b1 || if2.fwd_ready[0] !== 1'b0) begin
            n_err++; $display("FAIL miss_fwd0 got v=%b r=%b exp v=1 r=0", if2.fwd_valid[0], if2.fwd_ready[0]); end
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) begin cyc(); smp(); end
            n_vec++; if (if2.miss_stall !== 1'b1) begin n_err++; $display("FAIL miss_stall_c%0d got %b exp 1", k, if2.miss_stall); end
            n_vec++; if (if2.wb_write_enable !== 1'b0 || if4.wb_write_enable !== 1'b0) begin
                n_err++; $display("FAIL miss_no_wb_c%0d got %b/%b exp 0/0", k, if2.wb_write_enable, if4.wb_write_enable); end
        end
        cyc(); mem_ready = 1; dc_rdata = 64'hDEAD_BEEF; smp();
        n_vec++; if (if2.miss_stall !== 1'b0) begin n_err++; $display("FAIL miss_release got %b exp 0", if2.miss_stall); end
        cyc(); dc_miss = 0; mem_ready = 0; dc_rdata = 64'h0BAD; smp();
        n_vec++; if (if2.wb_write_enable !== 1'b1 || if2.wb_W_data !== 64'hDEAD_BEEF || if2.wb_W_regnum !== 5'd5) begin
            n_err++; $display("FAIL miss_wb got we=%b rn=%0d data=%h exp we=1 rn=5 data=deadbeef",
                              if2.wb_write_enable, if2.wb_W_regnum, if2.wb_W_data); end
        n_vec++; if (if2.fwd_ready[1] !== 1'b1) begin n_err++; $display("FAIL miss_fwd_ready1 got %b exp 1", if2.fwd_ready[1]); end
        cyc(); smp();
        n_vec++; if (if2.wb_write_enable !== 1'b0) begin n_err++; $display("FAIL miss_wb_once got %b exp 0", if2.wb_write_enable); end
        cyc(); smp();
        n_vec++; if (if4.wb_write_enable !== 1'b1 || if4.wb_W_data !== 64'hDEAD_BEEF) begin
            n_err++; $display("FAIL miss_wb4 got we=%b data=%h exp we=1 data=deadbeef", if4.wb_write_enable, if4.wb_W_data); end
        drain();
    endtask

    task automatic test_mmio();
        drive(5'd9, WB_LOAD, 64'h0, 1'b1);
        cyc(); set_idle(); smp();
        n_vec++; if (if2.miss_stall !== 1'b1) begin n_err++; $display("FAIL mmio_wait got %b exp 1", if2.miss_stall); end
        cyc(); d_valid = 1; d_rdata = 64'h55; dc_rdata = 64'hFF; smp();
        n_vec++; if (if2.miss_stall !== 1'b0) begin n_err++; $display("FAIL mmio_go got %b exp 0", if2.miss_stall); end
        cyc(); set_idle(); smp();
        n_vec++; if (if2.wb_write_enable !== 1'b1 || if2.wb_W_data !== 64'h55 || if2.wb_W_regnum !== 5'd9) begin
            n_err++; $display("FAIL mmio_wb got we=%b rn=%0d data=%h exp we=1 rn=9 data=55",
                              if2.wb_write_enable, if2.wb_W_regnum, if2.wb_W_data); end
        drain();
    endtask

    task automatic test_flush();
        drive(5'd7, WB_ALU, 64'h77, 1'b0); flush = 1;
        cyc(); set_idle(); smp();
        n_vec++; if (if2.fwd_valid !== 2'b00) begin n_err++; $display("FAIL flush_fwd_c1 got %b exp 00", if2.fwd_valid); end
        cyc(); smp();
        n_vec++; if (if2.wb_write_enable !== 1'b0 || if2.fwd_valid !== 2'b00) begin
            n_err++; $display("FAIL flush_wb got we=%b fv=%b exp we=0 fv=00", if2.wb_write_enable, if2.fwd_valid); end
        drain();
    endtask

    task automatic test_flush_stall();
        drive(5'd5, WB_LOAD, 64'h0, 1'b0);
        cyc(); drive(5'd7, WB_ALU, 64'h70, 1'b0); flush = 1; dc_miss = 1; smp();
        n_vec++; if (if2.miss_stall !== 1'b1) begin n_err++; $display("FAIL fs_stall got %b exp 1", if2.miss_stall); end
        cyc(); flush = 0; dc_miss = 0; dc_rdata = 64'h5A; smp();
        n_vec++; if (if2.miss_stall !== 1'b0) begin n_err++; $display("FAIL fs_release got %b exp 0", if2.miss_stall); end
        cyc(); set_idle(); smp();
        exp_rn2 = {5'd5, 5'd7};
        n_vec++; if (if2.fwd_valid !== 2'b11 || if2.fwd_regnum !== exp_rn2) begin
            n_err++; $display("FAIL fs_fwd got fv=%b rn=%h exp fv=11 rn=%h", if2.fwd_valid, if2.fwd_regnum, exp_rn2); end
        n_vec++; if (if2.wb_write_enable !== 1'b1 || if2.wb_W_data !== 64'h5A) begin
            n_err++; $display("FAIL fs_wb_load got we=%b data=%h exp we=1 data=5a", if2.wb_write_enable, if2.wb_W_data); end
        cyc(); smp();
        n_vec++; if (if2.wb_write_enable !== 1'b1 || if2.wb_W_regnum !== 5'd7 || if2.wb_W_data !== 64'h70) begin
            n_err++; $display("FAIL fs_wb_alu got we=%b rn=%0d data=%h exp we=1 rn=7 data=70",
                              if2.wb_write_enable, if2.wb_W_regnum, if2.wb_W_data); end
        drain();
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k <= 4; k++) begin
            drive(5'(k), WB_ALU, 64'(k * 'h11), 1'b0);
            cyc();
        end
        drive(5'd0, WB_ALU, 64'h99, 1'b0); smp();
        exp_rn4 = {5'd1, 5'd2, 5'd3, 5'd4};
        n_vec++; if (if4.fwd_regnum !== exp_rn4) begin n_err++; $display("FAIL b2b_fwd_rn got %h exp %h", if4.fwd_regnum, exp_rn4); end
        n_vec++; if (if4.fwd_valid !== 4'hF) begin n_err++; $display("FAIL b2b_fwd_valid got %b exp 1111", if4.fwd_valid); end
        n_vec++; if (if4.wb_write_enable !== 1'b1 || if4.wb_W_regnum !== 5'd1 || if4.wb_W_data !== 64'h11) begin
            n_err++; $display("FAIL b2b_wb1 got we=%b rn=%0d data=%h exp we=1 rn=1 data=11",
                              if4.wb_write_enable, if4.wb_W_regnum, if4.wb_W_data); end
        cyc(); set_idle(); smp();
        n_vec++; if (if4.fwd_valid !== 4'b1110) begin n_err++; $display("FAIL b2b_r0_fwd got %b exp 1110", if4.fwd_valid); end
        n_vec++; if (if4.wb_W_regnum !== 5'd2 || if4.wb_W_data !== 64'h22) begin
            n_err++; $display("FAIL b2b_wb2 got rn=%0d data=%h exp rn=2 data=22", if4.wb_W_regnum, if4.wb_W_data); end
        repeat (3) cyc();
        smp();
        n_vec++; if (if4.wb_write_enable !== 1'b0 || if4.fwd_data[255:192] !== 64'h99) begin
            n_err++; $display("FAIL b2b_r0_wb got we=%b d3=%h exp we=0 d3=99", if4.wb_write_enable, if4.fwd_data[255:192]); end
        drain();
    endtask

    task automatic test_reset_stall();
        drive(5'd2, WB_ALU, 64'h22, 1'b0);
        cyc(); drive(5'd6, WB_LOAD, 64'h0, 1'b0);
        cyc(); set_idle(); dc_miss = 1; smp();
        n_vec++; if (if2.miss_stall !== 1'b1 || if2.fwd_valid !== 2'b11 || if2.wb_write_enable !== 1'b0) begin
            n_err++; $display("FAIL rs_pre got st=%b fv=%b we=%b exp st=1 fv=11 we=0",
                              if2.miss_stall, if2.fwd_valid, if2.wb_write_enable); end
        #1 reset_n = 0;
        #1;
        n_vec++; if (if2.miss_stall !== 1'b0 || if2.wb_write_enable !== 1'b0 || if2.fwd_valid !== 2'b00) begin
            n_err++; $display("FAIL rs_async got st=%b we=%b fv=%b exp 0/0/00",
                              if2.miss_stall, if2.wb_write_enable, if2.fwd_valid); end
        n_vec++; if (if2.wb_W_data !== 64'd0 || if2.wb_W_regnum !== 5'd0 || if4.fwd_valid !== 4'd0) begin
            n_err++; $display("FAIL rs_clear got data=%h rn=%0d fv4=%b exp 0/0/0000",
                              if2.wb_W_data, if2.wb_W_regnum, if4.fwd_valid); end
        @(posedge clock);
        #1 reset_n = 1;
        for (int k = 0; k < 6; k++) begin
            smp();
            n_vec++; if (if2.wb_write_enable !== 1'b0 || if4.wb_write_enable !== 1'b0) begin
                n_err++; $display("FAIL rs_post_c%0d got %b/%b exp 0/0", k, if2.wb_write_enable, if4.wb_write_enable); end
            cyc();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_sel();
        test_cache_miss();
        test_mmio();
        test_flush();
        test_flush_stall();
        test_back_to_back();
        test_reset_stall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
